uart_rx_frame: RTL and testbench

- Serial UART receiver. Sits directly upstream of the system controller, through the data synchronizer.
- Oversamples RX_IN by a programmable prescale, deserialises LSB-first 8-bit frames and optionally checks parity.
- Emits a parallel byte with a one-cycle valid pulse. That pulse becomes the controller's RX_p_data / RX_d_valid.

---
 rtl/uart_rx_frame_if.sv | 25 ++
 rtl/uart_rx_frame.sv | 148 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// Serial-line and parallel-result signal bundle for the UART frame receiver.
// The slave modport is the receiver side; the master modport is the line/config driver side.
interface uart_rx_frame_if #(
    parameter int Data_width     = 8,
    parameter int Prescale_width = 6
);
    logic                      RX_IN;
    logic [Prescale_width-1:0] Prescale;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [Data_width-1:0]     P_DATA;
    logic                      data_valid;
    logic                      parity_error;
    logic                      stop_error;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, parity_error, stop_error
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, parity_error, stop_error
    );
endinterface

// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: majority-voted bit sampling, LSB-first deserialisation,
// optional parity, and one-cycle result pulses on the cycle the FSM returns to IDLE.
module uart_rx_frame #(
    parameter int Data_width     = 8,
    parameter int Prescale_width = 6
) (
    input  logic             CLK,
    input  logic             RST,
    uart_rx_frame_if.slave   rx
);
    localparam int PW = Prescale_width;
    localparam int CW = (Data_width > 1) ? $clog2(Data_width) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         edge_q, edge_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [2:0]            samp_q, samp_d;
    logic [Data_width-1:0] shift_q, shift_d;
    logic [PW-1:0]         p_q, p_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d;
    logic [Data_width-1:0] pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic [PW-1:0]         half;
    logic                  in_window, decide, wrap, maj, legal_p;

    always_comb begin
        half      = {1'b0, p_q[PW-1:1]};
        in_window = (edge_q == half - PW'(2)) || (edge_q == half - PW'(1)) || (edge_q == half);
        decide    = (edge_q == half + PW'(1));
        wrap      = (edge_q == p_q - PW'(1));
        maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
        legal_p   = (rx.Prescale == PW'(8)) || (rx.Prescale == PW'(16)) || (rx.Prescale == PW'(32));
    end

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        p_d       = p_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_err_d = par_err_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        if (state_q != IDLE) begin
            if (in_window) samp_d = {samp_q[1:0], rx.RX_IN};
            edge_d = wrap ? '0 : edge_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                // The detecting edge is edge_cnt 0 of the start bit, so counting resumes at 1.
                if (!rx.RX_IN) begin
                    state_d   = START;
                    edge_d    = PW'(1);
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    p_d       = legal_p ? rx.Prescale : PW'(8);
                    par_en_d  = rx.PAR_EN;
                    par_typ_d = rx.PAR_TYP;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) shift_d[bit_q] = maj;
                if (wrap) begin
                    if (bit_q == CW'(Data_width - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + CW'(1);
                    end
                end
            end
            PARITY: begin
                if (decide) par_err_d = maj ^ (^shift_q) ^ par_typ_q;
                if (wrap) state_d = STOP;
            end
            STOP: begin
                // The vote samples are untouched after the window, so maj is still the stop bit here.
                if (wrap) begin
                    state_d = IDLE;
                    pe_d    = par_err_q;
                    se_d    = ~maj;
                    dv_d    = ~par_err_q & maj;
                    if (~par_err_q & maj) pdata_d = shift_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            edge_q    <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            p_q       <= PW'(8);
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_err_q <= 1'b0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            p_q       <= p_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_err_q <= par_err_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    assign rx.P_DATA       = pdata_q;
    assign rx.data_valid   = dv_q;
    assign rx.parity_error = pe_q;
    assign rx.stop_error   = se_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: drives serial frames cycle by cycle and checks
// pulse timing, received bytes and error flags against hand-computed values.
module tb_uart_rx_frame;
    logic CLK;
    logic RST;

    uart_rx_frame_if #(.Data_width(8), .Prescale_width(6)) bus ();

    uart_rx_frame #(.Data_width(8), .Prescale_width(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .rx  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // g is the global cycle index; pulse times are logged relative to t0 (cycle 0 of a frame)
    int       g, t0;
    int       dv_n, pe_n, se_n, dv_at, dv_first_at, pe_at, se_at, consec;
    logic [7:0] dv_byte, dv_first_byte;
    logic     prev_dv;
    logic [10:0] bits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        dv_n = 0; pe_n = 0; se_n = 0;
        dv_at = -1; dv_first_at = -1; pe_at = -1; se_at = -1;
        dv_byte = '0; dv_first_byte = '0;
    endtask

    // Observe the outputs of cycle g (before edge g), then drive the line for edge g.
    task automatic step(input logic rxv, input logic rstv);
        @(negedge CLK);
        if (bus.data_valid) begin
            if (prev_dv) consec++;
            if (dv_n == 0) begin
                dv_first_at   = g - t0;
                dv_first_byte = bus.P_DATA;
            end
            dv_n++;
            dv_at   = g - t0;
            dv_byte = bus.P_DATA;
        end
        prev_dv = bus.data_valid;
        if (bus.parity_error) begin pe_n++; pe_at = g - t0; end
        if (bus.stop_error)   begin se_n++; se_at = g - t0; end
        bus.RX_IN = rxv;
        RST       = rstv;
        g++;
    endtask

    task automatic send(input logic [10:0] b, input int n, input int p);
        for (int c = 0; c < n * p; c++) step(b[c / p], 1'b0);
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++) step(1'b1, 1'b0);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic pen,
                                       input logic pb, input logic sb);
        logic [10:0] b;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        if (pen) begin
            b[9]  = pb;
            b[10] = sb;
        end else begin
            b[9] = sb;
        end
        return b;
    endfunction

    initial begin
        RST = 1'b1;
        bus.RX_IN = 1'b1; bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        g = 0; t0 = 0; consec = 0; prev_dv = 1'b0;
        clear_log();
        repeat (3) step(1'b1, 1'b1);
        repeat (2) step(1'b1, 1'b0);
        chk("reset_pdata", 32'(bus.P_DATA), 32'h00);
        chk("reset_dv",    32'(bus.data_valid), 32'h0);
        chk("reset_pe",    32'(bus.parity_error), 32'h0);
        chk("reset_se",    32'(bus.stop_error), 32'h0);

        // P=8, no parity, 0xA5
        clear_log(); t0 = g;
        send(mk(8'hA5, 1'b0, 1'b0, 1'b1), 10, 8); idle(4);
        chk("a5_dv_n", 32'(dv_n), 32'd1);
        chk("a5_dv_at", 32'(dv_at), 32'd80);
        chk("a5_byte", 32'(dv_byte), 32'hA5);
        chk("a5_err_n", 32'(pe_n + se_n), 32'd0);
        chk("a5_pdata_hold", 32'(bus.P_DATA), 32'hA5);

        // P=16, even parity, 0x3C good then bad parity
        bus.Prescale = 6'd16; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0;
        clear_log(); t0 = g;
        send(mk(8'h3C, 1'b1, 1'b0, 1'b1), 11, 16); idle(4);
        chk("3c_dv_at", 32'(dv_at), 32'd176);
        chk("3c_byte", 32'(dv_byte), 32'h3C);
        chk("3c_pe_n", 32'(pe_n), 32'd0);
        clear_log(); t0 = g;
        send(mk(8'h3C, 1'b1, 1'b1, 1'b1), 11, 16); idle(4);
        chk("3c_bad_pe_at", 32'(pe_at), 32'd176);
        chk("3c_bad_pe_n", 32'(pe_n), 32'd1);
        chk("3c_bad_dv_n", 32'(dv_n), 32'd0);
        chk("3c_bad_se_n", 32'(se_n), 32'd0);
        chk("3c_bad_pdata", 32'(bus.P_DATA), 32'h3C);

        // P=32, odd parity, 0x01 good then stop bit low
        bus.Prescale = 6'd32; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b1;
        clear_log(); t0 = g;
        send(mk(8'h01, 1'b1, 1'b0, 1'b1), 11, 32); idle(4);
        chk("01_dv_at", 32'(dv_at), 32'd352);
        chk("01_byte", 32'(dv_byte), 32'h01);
        chk("01_pe_n", 32'(pe_n), 32'd0);
        clear_log(); t0 = g;
        send(mk(8'h01, 1'b1, 1'b0, 1'b0), 11, 32); idle(4);
        chk("01_stop_se_at", 32'(se_at), 32'd352);
        chk("01_stop_dv_n", 32'(dv_n), 32'd0);
        chk("01_stop_pe_n", 32'(pe_n), 32'd0);
        chk("01_stop_pdata", 32'(bus.P_DATA), 32'h01);

        // Start glitch at P=8, then a clean 0x5A
        bus.Prescale = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        clear_log(); t0 = g;
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        idle(10);
        chk("glitch_pulses", 32'(dv_n + pe_n + se_n), 32'd0);
        t0 = g;
        send(mk(8'h5A, 1'b0, 1'b0, 1'b1), 10, 8); idle(4);
        chk("5a_dv_at", 32'(dv_at), 32'd80);
        chk("5a_byte", 32'(dv_byte), 32'h5A);

        // Back-to-back 0x11 then 0xEE with no idle gap
        clear_log(); t0 = g;
        send(mk(8'h11, 1'b0, 1'b0, 1'b1), 10, 8);
        send(mk(8'hEE, 1'b0, 1'b0, 1'b1), 10, 8); idle(4);
        chk("b2b_dv_n", 32'(dv_n), 32'd2);
        chk("b2b_first_at", 32'(dv_first_at), 32'd80);
        chk("b2b_first_byte", 32'(dv_first_byte), 32'h11);
        chk("b2b_second_at", 32'(dv_at), 32'd160);
        chk("b2b_second_byte", 32'(dv_byte), 32'hEE);

        // Single-cycle inversion at edge_cnt=3 of data bit 3 (line bit 4) of 0x96
        clear_log(); t0 = g;
        bits = mk(8'h96, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 80; c++) step((c == 35) ? ~bits[c / 8] : bits[c / 8], 1'b0);
        idle(4);
        chk("noise_dv_at", 32'(dv_at), 32'd80);
        chk("noise_byte", 32'(dv_byte), 32'h96);
        chk("noise_err_n", 32'(pe_n + se_n), 32'd0);

        // Reset at cycle 40 of a 0xFF frame, then 0x42
        clear_log(); t0 = g;
        bits = mk(8'hFF, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 90; c++) begin
            step((c < 80) ? bits[c / 8] : 1'b1, (c == 40));
            if (c == 41) begin
                chk("rst_pdata", 32'(bus.P_DATA), 32'h00);
                chk("rst_flags", 32'({bus.data_valid, bus.parity_error, bus.stop_error}), 32'h0);
            end
        end
        chk("rst_no_pulse", 32'(dv_n + pe_n + se_n), 32'd0);
        clear_log(); t0 = g;
        send(mk(8'h42, 1'b0, 1'b0, 1'b1), 10, 8); idle(4);
        chk("post_rst_dv_at", 32'(dv_at), 32'd80);
        chk("post_rst_byte", 32'(dv_byte), 32'h42);

        // Illegal prescale 12 behaves as 8
        bus.Prescale = 6'd12;
        clear_log(); t0 = g;
        send(mk(8'hC3, 1'b0, 1'b0, 1'b1), 10, 8); idle(4);
        chk("p12_dv_at", 32'(dv_at), 32'd80);
        chk("p12_byte", 32'(dv_byte), 32'hC3);

        chk("dv_never_consecutive", 32'(consec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
